// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// decimal-point bit position and the blank pattern.
package seg7_pkg;

  localparam int DP_BIT = 7;

  localparam logic [6:0] BLANK_SEGS = 7'h00;

  // Index is the hex nibble; bits are g..a.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_nibble_decode.sv
// Combinational hex nibble to active-high a..g segment pattern.
module seg7_nibble_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = SEG_LUT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: prescaled digit scan, load-strobed shadow
// registers, optional leading-zero blanking and registered segment/digit outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int CLK_DIV       = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    enable,
  output logic [7:0]              leds,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || CLK_DIV < 1) begin : g_bad_params
      $error("seg7_scan_driver: NUM_DIGITS must be 1..8 and CLK_DIV >= 1");
    end
  endgenerate

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    tick;

  assign tick = enable && (cnt == CNT_W'(CLK_DIV - 1));

  // Stage p0: prescaler, digit index and shadow capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (enable) begin
      if (tick) begin
        cnt <= '0;
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
    end
  end

  logic [3:0]            nib_p0;
  logic                  dp_p0;
  logic                  blank_p0;
  logic [6:0]            segs_p0;
  logic [7:0]            leds_p0;
  logic [NUM_DIGITS-1:0] sel_p0;

  // A digit above 0 is blank when it and every more-significant nibble are zero.
  always_comb begin
    nib_p0   = '0;
    dp_p0    = 1'b0;
    blank_p0 = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_p0   = shadow_val[4*i +: 4];
        dp_p0    = shadow_dp[i];
        blank_p0 = (BLANK_LEADING != 0) && (i != 0) && ((shadow_val >> (4*i)) == '0);
      end
    end
  end

  seg7_nibble_decode u_decode (
    .nibble (nib_p0),
    .segs   (segs_p0)
  );

  always_comb begin
    leds_p0 = 8'h00;
    sel_p0  = '1;
    if (enable) begin
      leds_p0[6:0]   = blank_p0 ? BLANK_SEGS : segs_p0;
      leds_p0[DP_BIT] = dp_p0;
      sel_p0         = ~(NUM_DIGITS'(1) << idx);
    end
  end

  // Stage p1: registered display outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds      <= 8'h00;
      digit_sel <= '1;
    end else begin
      leds      <= leds_p0;
      digit_sel <= sel_p0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (4 digits, 4-cycle dwell),
// with blanking enabled and disabled instances driven in parallel.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        enable;
  logic [7:0]  leds;
  logic [3:0]  digit_sel;
  logic [7:0]  leds_nb;
  logic [3:0]  digit_sel_nb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_LEADING(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .enable    (enable),
    .leds      (leds),
    .digit_sel (digit_sel)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_LEADING(0)) dut_nb (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .value     (value),
    .dp_in     (dp_in),
    .enable    (enable),
    .leds      (leds_nb),
    .digit_sel (digit_sel_nb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, capture v/dp with the display disabled, then enable scanning.
  // The next step() samples the first digit-0 output.
  task automatic start_scan(input logic [15:0] v, input logic [3:0] dp);
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0;
    step();
    step();
    reset_n = 1'b1; load = 1'b1; value = v; dp_in = dp;
    step();
    load = 1'b0; enable = 1'b1;
  endtask

  // Walk one full scan (4 digits x 4 cycles); exp_* pack digit d at [8d +: 8].
  task automatic run_scan(input string name, input logic [31:0] exp_bl, input logic [31:0] exp_nb);
    logic [3:0] exp_sel;
    for (int d = 0; d < 4; d++) begin
      exp_sel = ~(4'b0001 << d);
      for (int c = 0; c < 4; c++) begin
        step();
        checks++;
        if (leds !== exp_bl[8*d +: 8] || digit_sel !== exp_sel) begin
          errors++;
          $display("FAIL %s digit%0d cyc%0d: leds=%h sel=%b, required leds=%h sel=%b",
                   name, d, c, leds, digit_sel, exp_bl[8*d +: 8], exp_sel);
        end
        checks++;
        if (leds_nb !== exp_nb[8*d +: 8] || digit_sel_nb !== exp_sel) begin
          errors++;
          $display("FAIL %s_noblank digit%0d cyc%0d: leds=%h sel=%b, required leds=%h sel=%b",
                   name, d, c, leds_nb, digit_sel_nb, exp_nb[8*d +: 8], exp_sel);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (leds !== 8'h00 || digit_sel !== 4'b1111) begin
      errors++;
      $display("FAIL reset_async: leds=%h sel=%b, required 00/1111", leds, digit_sel);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (leds !== 8'h00 || digit_sel !== 4'b1111) begin
        errors++;
        $display("FAIL reset_hold: leds=%h sel=%b, required 00/1111", leds, digit_sel);
      end
    end
    reset_n = 1'b1; enable = 1'b1;
    run_scan("reset_scan", 32'h00_00_00_3F, 32'h3F_3F_3F_3F);
    step();
    checks++;
    if (leds !== 8'h3F || digit_sel !== 4'b1110) begin
      errors++;
      $display("FAIL reset_wrap: leds=%h sel=%b, required 3F/1110", leds, digit_sel);
    end
  endtask

  task automatic test_hex_scan();
    start_scan(16'h12AF, 4'b0100);
    run_scan("hex_scan", 32'h06_DB_77_71, 32'h06_DB_77_71);
    step();
    checks++;
    if (leds !== 8'h71 || digit_sel !== 4'b1110) begin
      errors++;
      $display("FAIL hex_wrap: leds=%h sel=%b, required 71/1110", leds, digit_sel);
    end
  endtask

  task automatic test_blanking();
    // Digit 3 carries a DP while blanked, so only the DP bit lights.
    start_scan(16'h0050, 4'b1000);
    run_scan("blanking", 32'h80_00_6D_3F, 32'hBF_3F_6D_3F);
  endtask

  task automatic test_enable_hold();
    start_scan(16'h4321, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (leds !== 8'h06 || digit_sel !== 4'b1110) begin
        errors++;
        $display("FAIL enable_pre: leds=%h sel=%b, required 06/1110", leds, digit_sel);
      end
    end
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (leds !== 8'h00 || digit_sel !== 4'b1111 || leds_nb !== 8'h00 || digit_sel_nb !== 4'b1111) begin
        errors++;
        $display("FAIL enable_off cyc%0d: leds=%h sel=%b, required 00/1111", k, leds, digit_sel);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (leds !== 8'h06 || digit_sel !== 4'b1110) begin
        errors++;
        $display("FAIL enable_resume cyc%0d: leds=%h sel=%b, required 06/1110", k, leds, digit_sel);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (leds !== 8'h5B || digit_sel !== 4'b1101) begin
        errors++;
        $display("FAIL enable_next cyc%0d: leds=%h sel=%b, required 5B/1101", k, leds, digit_sel);
      end
    end
  endtask

  task automatic test_load_tick_and_reset();
    start_scan(16'h4321, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (leds !== 8'h06 || digit_sel !== 4'b1110) begin
        errors++;
        $display("FAIL lt_pre cyc%0d: leds=%h sel=%b, required 06/1110", k, leds, digit_sel);
      end
    end
    // Next edge is the tick edge: load coincides with the index advance.
    load = 1'b1; value = 16'h8765;
    step();
    load = 1'b0;
    checks++;
    if (leds !== 8'h06 || digit_sel !== 4'b1110) begin
      errors++;
      $display("FAIL lt_edge: leds=%h sel=%b, required 06/1110", leds, digit_sel);
    end
    step();
    checks++;
    if (leds !== 8'h7D || digit_sel !== 4'b1101) begin
      errors++;
      $display("FAIL lt_new_digit: leds=%h sel=%b, required 7D/1101", leds, digit_sel);
    end
    // Mid-cycle reset with a load request that must not survive.
    #2;
    reset_n = 1'b0; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
    #1;
    checks++;
    if (leds !== 8'h00 || digit_sel !== 4'b1111) begin
      errors++;
      $display("FAIL midreset_async: leds=%h sel=%b, required 00/1111", leds, digit_sel);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (leds !== 8'h00 || digit_sel !== 4'b1111) begin
        errors++;
        $display("FAIL midreset_hold: leds=%h sel=%b, required 00/1111", leds, digit_sel);
      end
    end
    reset_n = 1'b1; load = 1'b0; enable = 1'b1;
    run_scan("midreset_scan", 32'h00_00_00_3F, 32'h3F_3F_3F_3F);
  endtask

  initial begin
    test_reset();
    test_hex_scan();
    test_blanking();
    test_enable_hold();
    test_load_tick_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 50000: clk cycles per digit dwell; legal range >=1.
REQ-003 Parameter BLANK_LEADING, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port load, input, 1 bit: capture strobe for value and dp_in.
REQ-007 Port value, input, 4*NUM_DIGITS bits: hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
REQ-008 Port dp_in, input, NUM_DIGITS bits: decimal point request per digit.
REQ-009 Port enable, input, 1 bit: 1 scans the display; 0 blanks the display and holds the scan.
REQ-010 Port leds, output, 8 bits: active-high segments; bit0..bit6 = a..g; bit7 = DP.
REQ-011 Port digit_sel, output, NUM_DIGITS bits: active-low one-hot digit enable; bit i selects digit i.

Function
REQ-012 Prescaler counts 0..CLK_DIV-1 while enable=1 and wraps to 0; tick is asserted in the cycle where the count equals CLK_DIV-1; CLK_DIV=1 asserts tick every cycle.
REQ-013 Digit index advances 0,1,..,NUM_DIGITS-1,0 on each tick; the wrap from NUM_DIGITS-1 to 0 is mandatory.
REQ-014 On a clk edge with load=1, shadow registers capture value and dp_in; the shadow registers hold when load=0.
REQ-015 leds and digit_sel are registered from the index and shadow registers, so the outputs change exactly one cycle after the index or shadow register changes.
REQ-016 Segment map (hex, bits g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
REQ-017 leds[7] equals shadow dp for the selected digit, including when that digit is blanked.
REQ-018 With BLANK_LEADING=1, digit i>0 shows segments 00 when its nibble and every more-significant nibble are 0; digit 0 is never blanked, so value 0 displays "0".
REQ-019 With enable=0: prescaler and index hold; leds=00; digit_sel is all ones on the next edge. After enable returns to 1, scanning resumes from the held count.
REQ-020 Simultaneous load and tick: the new shadow value and the new index take effect together, and the next output reflects both.
REQ-021 Exactly one digit_sel bit is low at any time while enable=1 and not in reset.

Reset
REQ-022 While reset_n=0 (asynchronous): prescaler=0, index=0, shadow value=0, shadow dp=0, leds=00, digit_sel all ones.
REQ-023 After reset_n deasserts with enable=1, the first output cycle shows digit 0 with "0" segments (leds=3F, digit_sel bit0 low).
REQ-024 Reset asserted mid-scan or during load discards all state; no partial capture survives.

Structure
REQ-025 Shared package seg7_pkg holds the 16-entry segment pattern constant array, the DP bit position constant, and the blank pattern constant.
REQ-026 Sub-module seg7_nibble_decode (combinational nibble-to-segments using seg7_pkg) is instantiated once on the selected nibble; prescaler, index, shadow and blanking logic live in seg7_scan_driver.
REQ-027 Elaboration fails when NUM_DIGITS is outside 1..8 or CLK_DIV is less than 1.

Verification (NUM_DIGITS=4, CLK_DIV=4)
REQ-028 Reset then enable=1, no load -> leds=3F, digit_sel=1110, and digit_sel bits 1..3 show blank (leds=00) in turn, each held 4 cycles.
REQ-029 load value=16'h12AF, dp_in=4'b0100 -> over one scan: digit0 leds=71, digit1 leds=77, digit2 leds=DB (5B plus DP), digit3 leds=06; index wraps to digit0 after 16 cycles.
REQ-030 load value=16'h0050 with BLANK_LEADING=1 -> digits 3 and 2 leds=00, digit1=6D, digit0=3F; the same stimulus with BLANK_LEADING=0 shows digits 3 and 2 as 3F.
REQ-031 enable dropped mid-dwell for 10 cycles -> leds=00 and digit_sel=1111 during the drop; the dwell then completes the remaining cycles on the same digit.
REQ-032 load asserted in the same cycle as tick, and reset_n pulsed low mid-scan -> the new digit shows the new nibble one cycle later; during reset the outputs go immediately to 00/1111, and after release the REQ-023 state appears.
